corefifo_gray_bin_pipe: RTL and testbench

Pipelined, multi-channel Gray/binary pointer converter for the COREFIFO pointer-synchronisation path. It sits after the pointer synchronisers and before the full/empty comparators. It splits the Gray-to-binary XOR chain across registered stages so wide pointers meet timing. Data moves through the stages under a valid/ready handshake with stall support. An optional monitor flags synchronised Gray samples that change more than one bit.

---
 rtl/corefifo_conv_pkg.sv | 32 +++
 rtl/corefifo_conv_stage.sv | 43 ++++
 rtl/corefifo_gray_bin_pipe.sv | 80 ++++++++
 tb/tb_corefifo_gray_bin_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/corefifo_conv_pkg.sv
// corefifo_conv_pkg: shared constants and conversion helpers for the COREFIFO Gray/binary pointer pipeline.
//   MODE_G2B / MODE_B2G : conversion direction selectors
//   word_t              : widest lane the helpers handle (MAXW bits, lanes are zero-extended)
//   ceil_div            : segment size per stage
//   gray2bin_seg        : resolve one bit range of a partially converted Gray word
//   bin2gray            : full binary-to-Gray conversion
//   popcount_gt1        : true when more than one bit is set
package corefifo_conv_pkg;
  localparam int MODE_G2B = 0;
  localparam int MODE_B2G = 1;
  localparam int MAXW = 64;
  typedef logic [MAXW-1:0] word_t;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  // Bits above hi are already binary, bits at/below lo are still Gray; the MSB
  // of the lane (w-1) is identical in both codes and is never touched.
  function automatic word_t gray2bin_seg(input word_t g, input int w, input int hi, input int lo);
    word_t b;
    b = g;
    for (int i = MAXW - 2; i >= 0; i--)
      if (i <= hi && i >= lo && i < w - 1) b[i] = b[i + 1] ^ g[i];
    return b;
  endfunction
  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction
  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_gt1(input word_t v);
    return (v & (v - word_t'(1))) != '0;
  endfunction
endpackage

// File: rtl/corefifo_conv_stage.sv
// corefifo_conv_stage: one valid/ready pipeline register converting bit range HI..LO of every lane.
//   clk, reset_n  : clock, async active-low reset (clears the valid bit only)
//   valid_i       : upstream word valid
//   load_o        : this stage captures at the next edge (empty or downstream loads)
//   next_load_i   : downstream stage loads (out_ready for the last stage)
//   data_i/data_o : CHANNELS lanes of W bits, partially converted on entry, further converted on exit
//   B2G           : apply full binary-to-Gray instead of the Gray segment (first stage of MODE=1)
//   HI < LO       : pure delay stage
module corefifo_conv_stage
  import corefifo_conv_pkg::*;
#(
  parameter int W        = 4,
  parameter int CHANNELS = 1,
  parameter int HI       = 3,
  parameter int LO       = 0,
  parameter bit B2G      = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_i,
  output logic                  load_o,
  input  logic                  next_load_i,
  input  logic [CHANNELS*W-1:0] data_i,
  output logic                  valid_o,
  output logic [CHANNELS*W-1:0] data_o
);
  logic                  valid_q;
  logic [CHANNELS*W-1:0] data_q, data_d;
  assign load_o  = ~valid_q | next_load_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  always_comb begin
    data_d = data_i;
    for (int c = 0; c < CHANNELS; c++)
      data_d[c*W +: W] = W'(B2G ? bin2gray(word_t'(data_i[c*W +: W]))
                                : gray2bin_seg(word_t'(data_i[c*W +: W]), W, HI, LO));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) valid_q <= 1'b0;
    else if (load_o) valid_q <= valid_i;
  always_ff @(posedge clk)
    if (load_o && valid_i) data_q <= data_d;
endmodule

// File: rtl/corefifo_gray_bin_pipe.sv
// corefifo_gray_bin_pipe: pipelined multi-channel Gray<->binary pointer converter with valid/ready stalls.
//   clk, reset_n         : clock, async active-low reset
//   in_valid/in_ready    : input handshake, in_ready is combinational from out_ready
//   in_data              : CHANNELS lanes of ADDRWIDTH+1 bits, lane c at [c*W +: W]
//   out_valid/out_ready  : output handshake
//   out_data             : converted lanes, latency STAGES
//   err_clr, gray_err    : only with COREFIFO_GRAY_CHECK_EN; sticky per-lane flag for
//                          accepted Gray samples differing from the previous one in >1 bit
module corefifo_gray_bin_pipe
  import corefifo_conv_pkg::*;
#(
  parameter int ADDRWIDTH = 3,
  parameter int CHANNELS  = 1,
  parameter int STAGES    = 2,
  parameter int MODE      = 0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CHANNELS*(ADDRWIDTH+1)-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHANNELS*(ADDRWIDTH+1)-1:0]   out_data
`ifdef COREFIFO_GRAY_CHECK_EN
  ,
  input  logic                                err_clr,
  output logic [CHANNELS-1:0]                 gray_err
`endif
);
  localparam int W  = ADDRWIDTH + 1;
  localparam int DW = CHANNELS * W;
  localparam int S  = ceil_div(W, STAGES);
  logic [STAGES:0]         vld, ld;
  logic [STAGES:0][DW-1:0] dat;
  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign ld[STAGES] = out_ready;
  assign in_ready   = ld[0];
  assign out_valid  = vld[STAGES];
  assign out_data   = dat[STAGES];
  // Stage k resolves the k-th S-bit slice from the MSB side; stages past the
  // last slice (and all but the first in MODE=1) only delay.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = (MODE == MODE_G2B) ? W - 1 - k * S : -1;
    localparam int LO = (W - (k + 1) * S > 0) ? W - (k + 1) * S : 0;
    corefifo_conv_stage #(
      .W(W), .CHANNELS(CHANNELS), .HI(HI), .LO(LO), .B2G(MODE == MODE_B2G && k == 0)
    ) u_stage (
      .clk(clk), .reset_n(reset_n),
      .valid_i(vld[k]), .load_o(ld[k]), .next_load_i(ld[k+1]),
      .data_i(dat[k]), .valid_o(vld[k+1]), .data_o(dat[k+1])
    );
  end
`ifdef COREFIFO_GRAY_CHECK_EN
  logic [DW-1:0]       hist_q;
  logic                hist_vld_q;
  logic [CHANNELS-1:0] gray_err_q, gray_err_d;
  logic                xfer;
  assign xfer     = in_valid & in_ready;
  assign gray_err = gray_err_q;
  // A new violation overrides a simultaneous clear.
  always_comb begin
    gray_err_d = gray_err_q & ~{CHANNELS{err_clr}};
    for (int c = 0; c < CHANNELS; c++)
      if (MODE == MODE_G2B && xfer && hist_vld_q &&
          popcount_gt1(word_t'(in_data[c*W +: W] ^ hist_q[c*W +: W]))) gray_err_d[c] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      gray_err_q <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      gray_err_q <= gray_err_d;
      if (xfer) hist_vld_q <= 1'b1;
    end
  always_ff @(posedge clk)
    if (xfer) hist_q <= in_data;
`endif
endmodule

// File: tb/tb_corefifo_gray_bin_pipe.sv
// tb_corefifo_gray_bin_pipe: directed self-checking bench over four converter configurations.
module tb_corefifo_gray_bin_pipe;
  logic clk, reset_n;
  logic v0, ir0, ov0, or0; logic [3:0]  i0, o0;
  logic v1, ir1, ov1, or1; logic [3:0]  i1, o1;
  logic v2, ir2, ov2, or2; logic [15:0] i2, o2;
  logic v3, ir3, ov3, or3; logic [3:0]  i3, o3;
  int n_tests, n_fail;
`ifdef COREFIFO_GRAY_CHECK_EN
  logic ec0, ec_n;
  logic [0:0] ge0, ge1, ge3;
  logic [1:0] ge2;
`endif

  // d0: W=4 STAGES=2 G2B, d1: W=4 STAGES=3 B2G, d2: 2x8-bit STAGES=4 G2B, d3: W=4 STAGES=1 G2B
  corefifo_gray_bin_pipe #(.ADDRWIDTH(3), .CHANNELS(1), .STAGES(2), .MODE(0)) d0 (
    .clk(clk), .reset_n(reset_n), .in_valid(v0), .in_ready(ir0), .in_data(i0),
    .out_valid(ov0), .out_ready(or0), .out_data(o0)
`ifdef COREFIFO_GRAY_CHECK_EN
    , .err_clr(ec0), .gray_err(ge0)
`endif
  );
  corefifo_gray_bin_pipe #(.ADDRWIDTH(3), .CHANNELS(1), .STAGES(3), .MODE(1)) d1 (
    .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(ir1), .in_data(i1),
    .out_valid(ov1), .out_ready(or1), .out_data(o1)
`ifdef COREFIFO_GRAY_CHECK_EN
    , .err_clr(ec_n), .gray_err(ge1)
`endif
  );
  corefifo_gray_bin_pipe #(.ADDRWIDTH(7), .CHANNELS(2), .STAGES(4), .MODE(0)) d2 (
    .clk(clk), .reset_n(reset_n), .in_valid(v2), .in_ready(ir2), .in_data(i2),
    .out_valid(ov2), .out_ready(or2), .out_data(o2)
`ifdef COREFIFO_GRAY_CHECK_EN
    , .err_clr(ec_n), .gray_err(ge2)
`endif
  );
  corefifo_gray_bin_pipe #(.ADDRWIDTH(3), .CHANNELS(1), .STAGES(1), .MODE(0)) d3 (
    .clk(clk), .reset_n(reset_n), .in_valid(v3), .in_ready(ir3), .in_data(i3),
    .out_valid(ov3), .out_ready(or3), .out_data(o3)
`ifdef COREFIFO_GRAY_CHECK_EN
    , .err_clr(ec_n), .gray_err(ge3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] g4(input int v);
    return 4'(v ^ (v >> 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    v0 = 0; v1 = 0; v2 = 0; v3 = 0;
    or0 = 1; or1 = 1; or2 = 1; or3 = 1;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;
`ifdef COREFIFO_GRAY_CHECK_EN
    ec0 = 0; ec_n = 0;
`endif
    step(); step();
    n_tests += 5;
    if ({ov0, ov1, ov2, ov3} !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0000", {ov0, ov1, ov2, ov3}); end
    if (ir0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", ir0); end
    reset_n = 1'b1;
    step();
    if ({ir0, ir1, ir2, ir3} !== 4'b1111) begin n_fail++; $display("FAIL release_in_ready got=%b want=1111", {ir0, ir1, ir2, ir3}); end
    if ({ov0, ov1, ov2, ov3} !== 4'b0000) begin n_fail++; $display("FAIL release_out_valid got=%b want=0000", {ov0, ov1, ov2, ov3}); end
`ifdef COREFIFO_GRAY_CHECK_EN
    if (ge0 !== 1'b0) begin n_fail++; $display("FAIL reset_gray_err got=%b want=0", ge0); end
`else
    if (ir3 !== 1'b1) begin n_fail++; $display("FAIL release_in_ready3 got=%b want=1", ir3); end
`endif
  endtask

  task automatic test_latency();
    v0 = 1; i0 = 4'b1101;
    v1 = 1; i1 = 4'b0110;
    v2 = 1; i2 = 16'h80FF;
    v3 = 1; i3 = 4'b1101;
    step();
    v0 = 0; v1 = 0; v2 = 0; v3 = 0;
    for (int s = 1; s <= 5; s++) begin
      n_tests += 4;
      if (ov0 !== (s == 2)) begin n_fail++; $display("FAIL lat_s2_valid cyc=%0d got=%b want=%b", s, ov0, s == 2); end
      if (ov1 !== (s == 3)) begin n_fail++; $display("FAIL lat_b2g_valid cyc=%0d got=%b want=%b", s, ov1, s == 3); end
      if (ov2 !== (s == 4)) begin n_fail++; $display("FAIL lat_2ch_valid cyc=%0d got=%b want=%b", s, ov2, s == 4); end
      if (ov3 !== (s == 1)) begin n_fail++; $display("FAIL lat_s1_valid cyc=%0d got=%b want=%b", s, ov3, s == 1); end
      if (s == 2) begin
        n_tests++;
        if (o0 !== 4'b1001) begin n_fail++; $display("FAIL g2b_1101 got=%b want=1001", o0); end
      end
      if (s == 3) begin
        n_tests++;
        if (o1 !== 4'b0101) begin n_fail++; $display("FAIL b2g_0110 got=%b want=0101", o1); end
      end
      if (s == 4) begin
        n_tests++;
        if (o2 !== 16'hFFAA) begin n_fail++; $display("FAIL g2b_2ch got=%h want=ffaa", o2); end
      end
      if (s == 1) begin
        n_tests++;
        if (o3 !== 4'b1001) begin n_fail++; $display("FAIL g2b_s1 got=%b want=1001", o3); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int pi, ci;
    logic xin;
    pi = 0; ci = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      v0 = (pi < 8);
      i0 = g4(pi);
      or0 = !(cyc >= 3 && cyc <= 5);
      #1;
      if (cyc < 8) begin
        n_tests++;
        if (ir0 !== !(cyc >= 3 && cyc <= 5)) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, ir0, !(cyc >= 3 && cyc <= 5)); end
      end
      if (cyc >= 3 && cyc <= 5) begin
        n_tests++;
        if (ov0 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", cyc, ov0); end
      end
      if (ov0 === 1'b1 && or0) begin
        n_tests++;
        if (ci >= 8 || o0 !== 4'(ci)) begin n_fail++; $display("FAIL bp_data idx=%0d got=%0d want=%0d", ci, o0, ci); end
        ci++;
      end
      xin = v0 & ir0;
      step();
      if (xin) pi++;
    end
    v0 = 0; or0 = 1;
    n_tests++;
    if (ci !== 8 || pi !== 8) begin n_fail++; $display("FAIL bp_count out=%0d in=%0d want=8/8", ci, pi); end
  endtask

  task automatic test_reset_mid();
    or0 = 0; v0 = 1;
    i0 = 4'b0011; step();
    i0 = 4'b0010; step();
    v0 = 0;
    n_tests += 3;
    if (ov0 !== 1'b1 || ir0 !== 1'b0) begin n_fail++; $display("FAIL mid_full got v=%b r=%b want v=1 r=0", ov0, ir0); end
    reset_n = 1'b0;
    #1;
    if (ov0 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b want=0", ov0); end
    if (ir0 !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got=%b want=1", ir0); end
    step();
    reset_n = 1'b1; or0 = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (ov0 !== 1'b0 || ir0 !== 1'b1) begin n_fail++; $display("FAIL mid_stale cyc=%0d got v=%b r=%b want v=0 r=1", c, ov0, ir0); end
    end
  endtask

`ifdef COREFIFO_GRAY_CHECK_EN
  task automatic accept0(input logic [3:0] d);
    v0 = 1; i0 = d; or0 = 1;
    step();
    v0 = 0; ec0 = 0;
  endtask

  task automatic test_gray_check();
    n_tests += 2;
    if (ge2 !== 2'b00 || ge3 !== 1'b0) begin n_fail++; $display("FAIL gc_single_word got=%b/%b want=00/0", ge2, ge3); end
    v1 = 1; i1 = 4'b0000; step(); i1 = 4'b1111; step(); v1 = 0; step();
    if (ge1 !== 1'b0) begin n_fail++; $display("FAIL gc_b2g_tied got=%b want=0", ge1); end
    reset_n = 0; step(); reset_n = 1; step();
    accept0(4'b1111);
    n_tests++;
    if (ge0 !== 1'b0) begin n_fail++; $display("FAIL gc_first_load got=%b want=0", ge0); end
    accept0(4'b0000);
    n_tests++;
    if (ge0 !== 1'b1) begin n_fail++; $display("FAIL gc_flip4 got=%b want=1", ge0); end
    reset_n = 0; #1;
    n_tests++;
    if (ge0 !== 1'b0) begin n_fail++; $display("FAIL gc_reset_clear got=%b want=0", ge0); end
    step(); reset_n = 1; step();
    accept0(4'b0000);
    accept0(4'b0001);
    n_tests++;
    if (ge0 !== 1'b0) begin n_fail++; $display("FAIL gc_one_bit got=%b want=0", ge0); end
    accept0(4'b0111);
    n_tests++;
    if (ge0 !== 1'b1) begin n_fail++; $display("FAIL gc_two_bit got=%b want=1", ge0); end
    step();
    n_tests++;
    if (ge0 !== 1'b1) begin n_fail++; $display("FAIL gc_sticky got=%b want=1", ge0); end
    ec0 = 1; step(); ec0 = 0;
    n_tests++;
    if (ge0 !== 1'b0) begin n_fail++; $display("FAIL gc_clear got=%b want=0", ge0); end
    ec0 = 1; accept0(4'b0000);
    n_tests++;
    if (ge0 !== 1'b1) begin n_fail++; $display("FAIL gc_set_wins got=%b want=1", ge0); end
    ec0 = 1; accept0(4'b0000);
    n_tests++;
    if (ge0 !== 1'b0) begin n_fail++; $display("FAIL gc_equal_clear got=%b want=0", ge0); end
    repeat (3) step();
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0;
    test_reset();
    test_latency();
    test_backpressure();
    test_reset_mid();
`ifdef COREFIFO_GRAY_CHECK_EN
    test_gray_check();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
